uart_tx_ctrl: RTL and testbench

//   UART 8N1 transmitter for the SDRAM read-back path. Pops bytes from the read-data FIFO
//   (filled by the SDRAM controller after a 0xAA read command) and serialises them on
//   RS232_tx, LSB first. It is the transmit counterpart of the rs232_rx command receiver and

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_ctrl_if.sv | 39 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive paths.
//   CLK_FREQ_DEF / BAUD_DEF : default sclk frequency and line rate
//   DATA_BITS               : data bits per frame (8N1)
//   uart_state_e            : transmitter FSM state encoding
//   bit_cycles()            : sclk cycles per bit (integer divide)
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 115200;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } uart_state_e;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: read-data FIFO handshake plus serial line and status of
// the UART transmitter.
//   fifo_empty  FIFO -> tx   FIFO has no data
//   fifo_dout   FIFO -> tx   FIFO output byte
//   fifo_rd_en  tx -> FIFO   one-cycle pop strobe
//   RS232_tx    tx -> line   serial output, idle high
//   tx_busy     tx -> user   frame in progress (fetch .. last stop cycle)
//   tx_done     tx -> user   one-cycle pulse on the last stop-bit cycle
//   dbg_state   tx -> debug  current FSM state
//
// Handshake: fifo_rd_en is a pop, not a request. The transmitter raises it
// for exactly one cycle, and only after it sampled fifo_empty == 0 while
// idle. The FIFO must then present the popped byte on fifo_dout FIFO_RD_LAT
// cycles later (0 = show-ahead: the byte is already valid during the pop
// cycle). fifo_empty is not looked at while a frame is in flight.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_rd_en;
    logic                 RS232_tx;
    logic                 tx_busy;
    logic                 tx_done;
    uart_state_e          dbg_state;

    // slave: the transmitter
    modport slave (
        input  fifo_empty, fifo_dout,
        output fifo_rd_en, RS232_tx, tx_busy, tx_done, dbg_state
    );

    // master: FIFO / environment side
    modport master (
        output fifo_empty, fifo_dout,
        input  fifo_rd_en, RS232_tx, tx_busy, tx_done, dbg_state
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
//   clk, rst   system clock, synchronous active-high reset
//   en_i       count while high
//   clr_i      force the count to 0 (has priority over en_i)
//   cnt_o      current position inside the bit, 0..BIT_CYC-1
//   bit_end_o  high during the last cycle of a bit (count BIT_CYC-1 and enabled)
module uart_baud_gen #(
    parameter  int BIT_CYC = 434,
    localparam int CW      = $clog2(BIT_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          bit_end_o
);

    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_end_o = en_i && (cnt_q == LAST);
        cnt_d     = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap on every bit boundary so the next bit starts at 0.
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART 8N1 transmitter for the SDRAM read-back path. Pops
// bytes from the read-data FIFO and serialises them LSB first on RS232_tx.
//   sclk        system clock
//   reset       synchronous, active-high reset
//   bus         uart_tx_ctrl_if.slave: fifo_empty, fifo_dout in;
//               fifo_rd_en, RS232_tx, tx_busy, tx_done, dbg_state out
// Parameters: CLK_FREQ, BAUD (bit period = CLK_FREQ/BAUD cycles, >= 2),
// FIFO_RD_LAT (cycles from pop to valid fifo_dout, 0 = show-ahead).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = CLK_FREQ_DEF,
    parameter int BAUD        = BAUD_DEF,
    parameter int FIFO_RD_LAT = 1
) (
    input  logic           sclk,
    input  logic           reset,
    uart_tx_ctrl_if.slave  bus
);

    localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
    localparam int CW      = $clog2(BIT_CYC);
    localparam int IW      = $clog2(DATA_BITS);
    localparam int WW      = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'(BIT_CYC - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((FIFO_RD_LAT > 0) ? FIFO_RD_LAT - 1 : 0);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [IW-1:0]        bit_idx_q;
    logic [WW-1:0]        wait_cnt_q;
    logic                 rd_en_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 cnt_en;
    logic                 bit_end;
    logic [CW-1:0]        bit_cnt;

    // The bit counter only runs while a line bit is being driven and is held
    // at 0 otherwise, so every START begins on a fresh bit period.
    assign cnt_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_baud_gen #(.BIT_CYC(BIT_CYC)) u_baud (
        .clk       (sclk),
        .rst       (reset),
        .en_i      (cnt_en),
        .clr_i     (!cnt_en),
        .cnt_o     (bit_cnt),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            wait_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            // Registered one cycle early so the pulse coincides with the
            // final stop-bit cycle.
            done_q  <= (state_q == ST_STOP) && (bit_cnt == PRE_LAST);

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!bus.fifo_empty) begin
                        state_q <= ST_FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    wait_cnt_q <= '0;
                    if (FIFO_RD_LAT == 0) begin
                        // Show-ahead FIFO: byte is valid during the pop cycle.
                        shreg_q <= bus.fifo_dout;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        shreg_q <= bus.fifo_dout;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q      <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            tx_q      <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.RS232_tx   = tx_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl. Three instances share
// one clock and reset: FIFO_RD_LAT = 1 (main, fed by a FIFO model), 0 and 2
// (start-bit latency only). Bit period is shortened to 8 cycles.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CLK_FREQ = 800_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CYC  = 8;
    localparam int HALF     = 4;
    localparam int RX_WAIT  = 400;

    // ---------------- clock / reset ----------------
    logic sclk  = 1'b0;
    logic reset = 1'b1;
    always #5 sclk = ~sclk;

    // ---------------- DUTs ----------------
    uart_tx_ctrl_if bus  ();
    uart_tx_ctrl_if bus0 ();
    uart_tx_ctrl_if bus2 ();

    uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_RD_LAT(1)) u_dut (
        .sclk (sclk), .reset (reset), .bus (bus)
    );
    uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_RD_LAT(0)) u_dut0 (
        .sclk (sclk), .reset (reset), .bus (bus0)
    );
    uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_RD_LAT(2)) u_dut2 (
        .sclk (sclk), .reset (reset), .bus (bus2)
    );

    // ---------------- FIFO model (latency 1) for main DUT ----------------
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge sclk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_dout <= mem[rd_ptr[9:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    logic empty0 = 1'b1;
    logic empty2 = 1'b1;
    assign bus0.fifo_empty = empty0;
    assign bus0.fifo_dout  = 8'hC3;
    assign bus2.fifo_empty = empty2;
    assign bus2.fifo_dout  = 8'hC3;

    // ---------------- event monitors (sampled at posedge, pre-update) ----------------
    int cyc         = 0;
    int rd_cnt      = 0;
    int busy_lo_cnt = 0;
    int done_cnt    = 0;

    always @(posedge sclk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
        if (bus.tx_busy === 1'b0) busy_lo_cnt <= busy_lo_cnt + 1;
        if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Receiver model: find the start edge, sample mid-bit.
    task automatic rx_frame(output logic [7:0] data, output bit frame_ok,
                            output bit found, output int start_cyc);
        int waited;
        waited    = 0;
        found     = 1'b0;
        frame_ok  = 1'b0;
        data      = '0;
        start_cyc = 0;
        while (!found && waited < RX_WAIT) begin
            @(negedge sclk);
            if (bus.RS232_tx === 1'b0) found = 1'b1;
            else waited++;
        end
        if (found) begin
            start_cyc = cyc;
            repeat (HALF) @(negedge sclk);
            frame_ok = (bus.RS232_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CYC) @(negedge sclk);
                data[i] = bus.RS232_tx;
            end
            repeat (BIT_CYC) @(negedge sclk);
            frame_ok = frame_ok && (bus.RS232_tx === 1'b1);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [9:0] line55;
    logic [7:0] burst [4];
    logic [7:0] rx_data;
    bit         rx_ok;
    bit         rx_found;
    int         rx_start;
    int         starts [4];
    int         bl     [4];
    int         bit_bad[10];
    int         bad_tx, bad_rd, bad_busy, done_bad, rd_bad;
    int         rd_before, done_before, waited, miss, ferr, derr;

    initial begin
        line55   = 10'b10_1010_1010;  // start, 1,0,1,0,1,0,1,0 (0x55 LSB first), stop
        burst[0] = 8'h12;
        burst[1] = 8'h34;
        burst[2] = 8'h56;
        burst[3] = 8'h78;

        // ---- reset state ----
        repeat (3) @(negedge sclk);
        check("rst_tx",    32'(bus.RS232_tx),   32'd1);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_busy",  32'(bus.tx_busy),    32'd0);
        check("rst_done",  32'(bus.tx_done),    32'd0);
        check("rst_state", 32'(bus.dbg_state),  32'(ST_IDLE));
        check("rst_tx0",   32'(bus0.RS232_tx),  32'd1);
        check("rst_tx2",   32'(bus2.RS232_tx),  32'd1);
        reset = 1'b0;

        // ---- 1: idle with empty FIFO ----
        bad_tx = 0; bad_rd = 0; bad_busy = 0;
        repeat (10000) begin
            @(negedge sclk);
            if (bus.RS232_tx !== 1'b1)   bad_tx++;
            if (bus.fifo_rd_en !== 1'b0) bad_rd++;
            if (bus.tx_busy !== 1'b0)    bad_busy++;
        end
        check("idle_tx_not_high", 32'(bad_tx),   32'd0);
        check("idle_rd_en_high",  32'(bad_rd),   32'd0);
        check("idle_busy_high",   32'(bad_busy), 32'd0);

        // ---- 2: single byte 0x55 ----
        rd_before   = rd_cnt;
        done_before = done_cnt;
        push(8'h55);
        @(negedge sclk);  // FETCH cycle (T+1)
        check("t2_fetch_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        check("t2_fetch_busy",  32'(bus.tx_busy),    32'd1);
        check("t2_fetch_tx",    32'(bus.RS232_tx),   32'd1);
        check("t2_fetch_state", 32'(bus.dbg_state),  32'(ST_FETCH));
        @(negedge sclk);  // WAIT cycle (T+2)
        check("t2_wait_rd_en",  32'(bus.fifo_rd_en), 32'd0);
        check("t2_wait_tx",     32'(bus.RS232_tx),   32'd1);
        done_bad = 0; rd_bad = 0;
        for (int b = 0; b < 10; b++) bit_bad[b] = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < BIT_CYC; k++) begin
                @(negedge sclk);
                if (bus.RS232_tx !== line55[b]) bit_bad[b]++;
                if (bus.tx_done !== ((b == 9) && (k == BIT_CYC - 1))) done_bad++;
                if (bus.fifo_rd_en !== 1'b0) rd_bad++;
            end
        end
        for (int b = 0; b < 10; b++)
            check($sformatf("t2_line_bit%0d_bad_cycles", b), 32'(bit_bad[b]), 32'd0);
        check("t2_done_timing", 32'(done_bad), 32'd0);
        check("t2_rd_en_extra", 32'(rd_bad),   32'd0);
        @(negedge sclk);
        check("t2_after_tx",    32'(bus.RS232_tx), 32'd1);
        check("t2_after_busy",  32'(bus.tx_busy),  32'd0);
        check("t2_after_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("t2_rd_pulses",   32'(rd_cnt - rd_before),     32'd1);
        check("t2_done_pulses", 32'(done_cnt - done_before), 32'd1);

        // ---- 3: burst of four bytes ----
        repeat (5) @(negedge sclk);
        rd_before   = rd_cnt;
        done_before = done_cnt;
        for (int i = 0; i < 4; i++) push(burst[i]);
        for (int i = 0; i < 4; i++) begin
            rx_frame(rx_data, rx_ok, rx_found, rx_start);
            starts[i] = rx_start;
            bl[i]     = busy_lo_cnt;
            check($sformatf("t3_found%0d", i), 32'(rx_found), 32'd1);
            check($sformatf("t3_frame%0d", i), 32'(rx_ok),    32'd1);
            check($sformatf("t3_data%0d", i),  32'(rx_data),  32'(burst[i]));
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_gap%0d", i), 32'(starts[i+1] - starts[i]), 32'd83);
        check("t3_busy_low_cycles", 32'(bl[3] - bl[0]), 32'd3);
        repeat (BIT_CYC) @(negedge sclk);
        check("t3_rd_pulses",   32'(rd_cnt - rd_before),     32'd4);
        check("t3_done_pulses", 32'(done_cnt - done_before), 32'd4);

        // ---- 4: reset in the middle of data bit 3 of 0xAA ----
        repeat (5) @(negedge sclk);
        done_before = done_cnt;
        push(8'hAA);
        push(8'h3C);
        waited = 0;
        while ((bus.RS232_tx !== 1'b0) && (waited < RX_WAIT)) begin
            @(negedge sclk);
            waited++;
        end
        check("t4_start_seen", 32'(bus.RS232_tx), 32'd0);
        repeat (4 * BIT_CYC + HALF) @(negedge sclk);
        check("t4_pre_state", 32'(bus.dbg_state), 32'(ST_DATA));
        check("t4_pre_bit3",  32'(bus.RS232_tx),  32'd1);
        reset = 1'b1;
        @(negedge sclk);
        check("t4_rst_tx",    32'(bus.RS232_tx),   32'd1);
        check("t4_rst_busy",  32'(bus.tx_busy),    32'd0);
        check("t4_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("t4_rst_state", 32'(bus.dbg_state),  32'(ST_IDLE));
        reset = 1'b0;
        rx_frame(rx_data, rx_ok, rx_found, rx_start);
        check("t4_next_found", 32'(rx_found), 32'd1);
        check("t4_next_frame", 32'(rx_ok),    32'd1);
        check("t4_next_data",  32'(rx_data),  32'h3C);
        repeat (BIT_CYC) @(negedge sclk);
        check("t4_done_pulses", 32'(done_cnt - done_before), 32'd1);

        // ---- 5: FIFO_RD_LAT = 0 and 2 start-bit latency ----
        empty0 = 1'b0;
        @(negedge sclk);
        check("t5_lat0_rd_en", 32'(bus0.fifo_rd_en), 32'd1);
        check("t5_lat0_tx_t1", 32'(bus0.RS232_tx),   32'd1);
        empty0 = 1'b1;
        @(negedge sclk);
        check("t5_lat0_start_t2", 32'(bus0.RS232_tx),   32'd0);
        check("t5_lat0_rd_off",   32'(bus0.fifo_rd_en), 32'd0);
        repeat (BIT_CYC) @(negedge sclk);
        check("t5_lat0_d0", 32'(bus0.RS232_tx), 32'd1);
        repeat (2 * BIT_CYC) @(negedge sclk);
        check("t5_lat0_d2", 32'(bus0.RS232_tx), 32'd0);

        empty2 = 1'b0;
        @(negedge sclk);
        check("t5_lat2_rd_en", 32'(bus2.fifo_rd_en), 32'd1);
        empty2 = 1'b1;
        @(negedge sclk);
        check("t5_lat2_tx_t2", 32'(bus2.RS232_tx),   32'd1);
        check("t5_lat2_rd_off", 32'(bus2.fifo_rd_en), 32'd0);
        @(negedge sclk);
        check("t5_lat2_tx_t3", 32'(bus2.RS232_tx), 32'd1);
        @(negedge sclk);
        check("t5_lat2_start_t4", 32'(bus2.RS232_tx), 32'd0);

        // ---- 6: loopback of all 256 byte values ----
        repeat (5) @(negedge sclk);
        done_before = done_cnt;
        miss = 0; ferr = 0; derr = 0;
        for (int v = 0; v < 256; v++) push(8'(v));
        for (int v = 0; v < 256; v++) begin
            rx_frame(rx_data, rx_ok, rx_found, rx_start);
            if (!rx_found) begin
                miss++;
                break;
            end
            if (!rx_ok) ferr++;
            if (rx_data !== 8'(v)) derr++;
        end
        check("t6_missing_frames", 32'(miss), 32'd0);
        check("t6_framing_errors", 32'(ferr), 32'd0);
        check("t6_data_errors",    32'(derr), 32'd0);
        repeat (BIT_CYC) @(negedge sclk);
        check("t6_done_pulses", 32'(done_cnt - done_before), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
